// File: rtl/calc_pkg.sv
// Shared types and defaults for the four-function calculator sequencer.
package calc_pkg;

    localparam int unsigned CALC_WIDTH = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        MTEST,
        MADD,
        MSHIFT,
        DSHIFT,
        DSUB,
        FIN
    } state_t;

endpackage

// File: rtl/calc_op_sequencer_if.sv
// Request/result bundle between the operand registers and the calculator sequencer.
interface calc_op_sequencer_if
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = CALC_WIDTH
) ();

    logic               start;
    op_t                op;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] result;
    logic               carry;
    logic               div_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result, carry, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, carry, div_zero
    );

endinterface

// File: rtl/calc_iter_datapath.sv
// Shared shift-add / restoring shift-subtract datapath: M/D, Acc/R, Q, C and bit counter.
// Strobes are applied on the clock edge; the *_o result views show the value the next edge produces.
module calc_iter_datapath
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = CALC_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               add_i,
    input  logic               mshift_i,
    input  logic               dshift_i,
    input  logic               dsub_i,
    input  logic               dec_i,
    input  logic [WIDTH-1:0]   m_i,
    input  logic [WIDTH-1:0]   q_i,
    output logic               q0_o,
    output logic               cnt_zero_o,
    output logic               r_ge_d_o,
    output logic [2*WIDTH-1:0] prod_o,
    output logic [WIDTH-1:0]   rem_next_o,
    output logic [WIDTH-2:0]   q_hi_o
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] rem;
    logic             r_ge_d;

    // During division C acts as the remainder's extra top bit so 2R+1 never overflows.
    assign sum    = {1'b0, acc_q} + {1'b0, m_q};
    assign rem    = acc_q - m_q;
    assign r_ge_d = {c_q, acc_q} >= {1'b0, m_q};

    always_comb begin
        m_d   = m_q;
        acc_d = acc_q;
        q_d   = q_q;
        c_d   = c_q;
        cnt_d = cnt_q;
        if (load_i) begin
            m_d   = m_i;
            q_d   = q_i;
            acc_d = '0;
            c_d   = 1'b0;
            cnt_d = CW'(WIDTH - 1);
        end else if (add_i) begin
            {c_d, acc_d} = sum;
        end else if (mshift_i) begin
            {c_d, acc_d, q_d} = {1'b0, c_q, acc_q, q_q[WIDTH-1:1]};
        end else if (dshift_i) begin
            {c_d, acc_d, q_d} = {acc_q, q_q, 1'b0};
        end else if (dsub_i) begin
            acc_d = r_ge_d ? rem : acc_q;
            q_d   = {q_q[WIDTH-1:1], r_ge_d};
            c_d   = 1'b0;
        end
        if (dec_i) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_q   <= '0;
            acc_q <= '0;
            q_q   <= '0;
            c_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            m_q   <= m_d;
            acc_q <= acc_d;
            q_q   <= q_d;
            c_q   <= c_d;
            cnt_q <= cnt_d;
        end
    end

    assign q0_o       = q_q[0];
    assign cnt_zero_o = (cnt_q == '0);
    assign r_ge_d_o   = r_ge_d;
    assign prod_o     = {c_q, acc_q, q_q[WIDTH-1:1]};
    assign rem_next_o = r_ge_d ? rem : acc_q;
    assign q_hi_o     = q_q[WIDTH-1:1];

endmodule

// File: rtl/calc_op_sequencer.sv
// Four-function calculator sequencer: ADD/SUB in one execute cycle, MUL/DIV iterated on a shared datapath.
// Start is only sampled in IDLE; results are registered on entry to FIN, where Done pulses for one cycle.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = CALC_WIDTH
) (
    input  logic          clk_i,
    input  logic          rst_i,
    calc_op_sequencer_if.slave bus
);

    state_t               state_q, state_d;
    op_t                  op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 carry_q, carry_d;
    logic                 div_zero_q, div_zero_d;

    logic                 dp_load, dp_add, dp_mshift, dp_dshift, dp_dsub, dp_dec;
    logic [WIDTH-1:0]     dp_m, dp_q;
    logic                 dp_q0, dp_cnt_zero, dp_r_ge_d;
    logic [2*WIDTH-1:0]   dp_prod;
    logic [WIDTH-1:0]     dp_rem_next;
    logic [WIDTH-2:0]     dp_q_hi;

    logic [WIDTH:0]       sum_ab;
    logic [WIDTH-1:0]     diff_ab;

    assign sum_ab  = {1'b0, a_q} + {1'b0, b_q};
    assign diff_ab = a_q - b_q;

    // Multiply keeps the multiplicand in M and the multiplier in Q; divide swaps roles.
    assign dp_m = (bus.op == OP_DIV) ? bus.b : bus.a;
    assign dp_q = (bus.op == OP_DIV) ? bus.a : bus.b;

    calc_iter_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (dp_load),
        .add_i      (dp_add),
        .mshift_i   (dp_mshift),
        .dshift_i   (dp_dshift),
        .dsub_i     (dp_dsub),
        .dec_i      (dp_dec),
        .m_i        (dp_m),
        .q_i        (dp_q),
        .q0_o       (dp_q0),
        .cnt_zero_o (dp_cnt_zero),
        .r_ge_d_o   (dp_r_ge_d),
        .prod_o     (dp_prod),
        .rem_next_o (dp_rem_next),
        .q_hi_o     (dp_q_hi)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        carry_d    = carry_q;
        div_zero_d = div_zero_q;
        dp_load    = 1'b0;
        dp_add     = 1'b0;
        dp_mshift  = 1'b0;
        dp_dshift  = 1'b0;
        dp_dsub    = 1'b0;
        dp_dec     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    dp_load = 1'b1;
                    unique case (bus.op)
                        OP_ADD, OP_SUB: state_d = EXEC;
                        OP_MUL:         state_d = MTEST;
                        default: begin
                            if (bus.b == '0) begin
                                state_d    = FIN;
                                result_d   = '0;
                                carry_d    = 1'b0;
                                div_zero_d = 1'b1;
                            end else begin
                                state_d = DSHIFT;
                            end
                        end
                    endcase
                end
            end
            EXEC: begin
                state_d    = FIN;
                div_zero_d = 1'b0;
                if (op_q == OP_ADD) begin
                    result_d = {{(WIDTH-1){1'b0}}, sum_ab};
                    carry_d  = sum_ab[WIDTH];
                end else begin
                    result_d = {{WIDTH{1'b0}}, diff_ab};
                    carry_d  = (a_q < b_q);
                end
            end
            MTEST: begin
                state_d = dp_q0 ? MADD : MSHIFT;
            end
            MADD: begin
                dp_add  = 1'b1;
                state_d = MSHIFT;
            end
            MSHIFT: begin
                dp_mshift = 1'b1;
                if (dp_cnt_zero) begin
                    state_d    = FIN;
                    result_d   = dp_prod;
                    carry_d    = 1'b0;
                    div_zero_d = 1'b0;
                end else begin
                    dp_dec  = 1'b1;
                    state_d = MTEST;
                end
            end
            DSHIFT: begin
                dp_dshift = 1'b1;
                state_d   = DSUB;
            end
            DSUB: begin
                dp_dsub = 1'b1;
                if (dp_cnt_zero) begin
                    state_d    = FIN;
                    result_d   = {dp_rem_next, dp_q_hi, dp_r_ge_d};
                    carry_d    = 1'b0;
                    div_zero_d = 1'b0;
                end else begin
                    dp_dec  = 1'b1;
                    state_d = DSHIFT;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            op_q       <= OP_ADD;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == FIN);
    assign bus.result   = result_q;
    assign bus.carry    = carry_q;
    assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Randomised and directed bench for calc_op_sequencer against an arithmetic reference model.
module tb_calc_op_sequencer;
    import calc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    calc_op_sequencer_if bus ();

    calc_op_sequencer dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void model(input op_t op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [15:0] r, output logic c, output logic dz,
                                  output int lat);
        int ai, bi;
        ai = int'(a);
        bi = int'(b);
        c  = 1'b0;
        dz = 1'b0;
        case (op)
            OP_ADD: begin r = 16'(ai + bi); c = (ai + bi) > 255; lat = 2; end
            OP_SUB: begin r = {8'h00, 8'(ai - bi)}; c = ai < bi; lat = 2; end
            OP_MUL: begin r = 16'(ai * bi); lat = 17 + $countones(b); end
            default: begin
                if (bi == 0) begin r = 16'h0000; dz = 1'b1; lat = 1; end
                else begin r = 16'(((ai % bi) << 8) | (ai / bi)); lat = 17; end
            end
        endcase
    endfunction

    // Issues one request from IDLE, scrambles the inputs while busy, and reports what came back.
    task automatic run_op(input op_t op, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output logic [15:0] r, output logic c, output logic dz,
                          output logic [2:0] hs);
        logic got;
        logic busy_at_done;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
        bus.op = op_t'($urandom_range(0, 3));
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            if (bus.done === 1'b1) got = 1'b1;
        end
        if (!got) lat = -1;
        r = bus.result; c = bus.carry; dz = bus.div_zero;
        busy_at_done = bus.busy;
        @(negedge clk);
        hs = {busy_at_done, bus.busy, bus.done};
    endtask

    task automatic test_reset();
        bus.start = 1'b1; bus.op = OP_MUL; bus.a = 8'h12; bus.b = 8'h34;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({bus.busy, bus.done, bus.result, bus.carry, bus.div_zero} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got busy=%b done=%b result=%h carry=%b dz=%b want all 0",
                     bus.busy, bus.done, bus.result, bus.carry, bus.div_zero);
        end
        bus.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_idle got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_add_sub();
        op_t op; logic [7:0] a, b; logic [15:0] r, er; logic c, ec, dz, edz; int lat, elat;
        logic [2:0] hs;
        for (int i = 0; i < 24; i++) begin
            op = (i == 0 || i == 3) ? OP_ADD : (i < 5) ? OP_SUB : op_t'($urandom_range(0, 1));
            case (i)
                0: begin a = 8'hC8; b = 8'h64; end
                1: begin a = 8'h05; b = 8'h0A; end
                2: begin a = 8'h0A; b = 8'h05; end
                3: begin a = 8'hFF; b = 8'hFF; end
                4: begin a = 8'h00; b = 8'hFF; end
                default: begin a = 8'($urandom); b = 8'($urandom); end
            endcase
            model(op, a, b, er, ec, edz, elat);
            run_op(op, a, b, lat, r, c, dz, hs);
            vectors++;
            if ({r, c, dz} !== {er, ec, edz}) begin
                miscompares++;
                $display("FAIL add_sub[%0d] op=%0d a=%h b=%h result/carry/dz got %h/%b/%b want %h/%b/%b",
                         i, op, a, b, r, c, dz, er, ec, edz);
            end
            vectors++;
            if (lat != elat) begin
                miscompares++;
                $display("FAIL add_sub[%0d] latency got %0d want %0d", i, lat, elat);
            end
            vectors++;
            if (hs !== 3'b100) begin
                miscompares++;
                $display("FAIL add_sub[%0d] busy_at_done/busy_after/done_after got %b want 100", i, hs);
            end
        end
    endtask

    task automatic test_mul();
        logic [7:0] a, b; logic [15:0] r, er; logic c, ec, dz, edz; int lat, elat;
        logic [2:0] hs;
        for (int i = 0; i < 12; i++) begin
            case (i)
                0: begin a = 8'hFF; b = 8'hFF; end
                1: begin a = 8'h0D; b = 8'h00; end
                2: begin a = 8'h00; b = 8'hA5; end
                default: begin a = 8'($urandom); b = 8'($urandom); end
            endcase
            model(OP_MUL, a, b, er, ec, edz, elat);
            run_op(OP_MUL, a, b, lat, r, c, dz, hs);
            vectors++;
            if ({r, c, dz} !== {er, ec, edz}) begin
                miscompares++;
                $display("FAIL mul[%0d] a=%h b=%h result/carry/dz got %h/%b/%b want %h/%b/%b",
                         i, a, b, r, c, dz, er, ec, edz);
            end
            vectors++;
            if (lat != elat) begin
                miscompares++;
                $display("FAIL mul[%0d] latency got %0d want %0d", i, lat, elat);
            end
            vectors++;
            if (hs !== 3'b100) begin
                miscompares++;
                $display("FAIL mul[%0d] busy_at_done/busy_after/done_after got %b want 100", i, hs);
            end
        end
    endtask

    task automatic test_div();
        logic [7:0] a, b; logic [15:0] r, er; logic c, ec, dz, edz; int lat, elat;
        logic [2:0] hs;
        for (int i = 0; i < 16; i++) begin
            case (i)
                0: begin a = 8'hC8; b = 8'h07; end
                1: begin a = 8'h55; b = 8'h00; end
                2: begin a = 8'hFF; b = 8'hC8; end
                3: begin a = 8'h03; b = 8'hFF; end
                4: begin a = 8'hFF; b = 8'h01; end
                default: begin
                    a = 8'($urandom);
                    b = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
                end
            endcase
            model(OP_DIV, a, b, er, ec, edz, elat);
            run_op(OP_DIV, a, b, lat, r, c, dz, hs);
            vectors++;
            if ({r, c, dz} !== {er, ec, edz}) begin
                miscompares++;
                $display("FAIL div[%0d] a=%h b=%h result/carry/dz got %h/%b/%b want %h/%b/%b",
                         i, a, b, r, c, dz, er, ec, edz);
            end
            vectors++;
            if (lat != elat) begin
                miscompares++;
                $display("FAIL div[%0d] latency got %0d want %0d", i, lat, elat);
            end
            vectors++;
            if (hs !== 3'b100) begin
                miscompares++;
                $display("FAIL div[%0d] busy_at_done/busy_after/done_after got %b want 100", i, hs);
            end
        end
    endtask

    task automatic test_ignore_and_abort();
        int dones; logic [15:0] res;
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MUL; bus.a = 8'h12; bus.b = 8'h34;
        @(posedge clk);
        #1 bus.start = 1'b0;
        dones = 0;
        res = 16'h0000;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin dones++; res = bus.result; end
            if (cyc == 3) begin bus.start = 1'b1; bus.op = OP_ADD; bus.a = 8'h01; bus.b = 8'h02; end
            if (cyc == 4) bus.start = 1'b0;
        end
        vectors++;
        if (dones != 1 || res !== 16'h03A8) begin
            miscompares++;
            $display("FAIL ignore_start got dones=%0d result=%h want 1 and 03a8", dones, res);
        end

        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MUL; bus.a = 8'($urandom); bus.b = 8'hFF;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_busy_before got %b want 1", bus.busy);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.busy, bus.done, bus.result, bus.carry, bus.div_zero} !== 19'd0) begin
            miscompares++;
            $display("FAIL abort_clear got busy=%b done=%b result=%h carry=%b dz=%b want all 0",
                     bus.busy, bus.done, bus.result, bus.carry, bus.div_zero);
        end
        dones = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        vectors++;
        if (dones != 0) begin
            miscompares++;
            $display("FAIL abort_no_done got %0d done pulses want 0", dones);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b; logic [15:0] er; logic ec, edz; int lat, elat, dones;
        logic busy_first, got;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = OP_ADD;
        for (int k = 0; k < 3; k++) begin
            a = 8'($urandom); b = 8'($urandom);
            bus.a = a; bus.b = b;
            model(OP_ADD, a, b, er, ec, edz, elat);
            lat = 0; got = 1'b0; busy_first = 1'b0; dones = 0;
            while (!got && lat < 10) begin
                @(negedge clk);
                lat++;
                if (lat == 1) busy_first = bus.busy;
                if (bus.done === 1'b1) begin got = 1'b1; dones++; end
            end
            if (k == 2) bus.start = 1'b0;
            vectors++;
            if ({bus.result, bus.carry, bus.div_zero} !== {er, ec, edz}) begin
                miscompares++;
                $display("FAIL b2b[%0d] result/carry/dz got %h/%b/%b want %h/%b/%b",
                         k, bus.result, bus.carry, bus.div_zero, er, ec, edz);
            end
            vectors++;
            if (lat != ((k == 0) ? 2 : 3) || bus.busy !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b[%0d] done_spacing got %0d busy=%b want %0d busy=1",
                         k, lat, bus.busy, (k == 0) ? 2 : 3);
            end
            if (k > 0) begin
                vectors++;
                if (busy_first !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b[%0d] idle_gap busy got %b want 0", k, busy_first);
                end
            end
        end
        dones = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        vectors++;
        if (dones != 0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_tail got dones=%0d busy=%b want 0 0", dones, bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_ignore_and_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/calc_op_sequencer.md
# calc_op_sequencer

Multi-cycle arithmetic sequencer for the four-function calculator. It accepts one operation request (ADD, SUB, MUL, DIV) on 8-bit unsigned operands and returns a registered 16-bit result with a one-cycle done pulse. It sits between the keypad/operand registers and the display formatter.

- ADD and SUB finish in a single execute cycle.
- MUL is sequenced as shift-add on a shared accumulator datapath.
- DIV is sequenced as restoring shift-subtract on the same datapath.

## Interface
- WIDTH, 8: operand width; result is 2*WIDTH.
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high; returns block to IDLE.
- Start  in  1  request; sampled only in IDLE.
- Op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV; sampled with Start.
- A  in  WIDTH  operand / multiplicand / dividend.
- B  in  WIDTH  operand / multiplier / divisor.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse; Result and flags are valid from this cycle.
- Result  out  2*WIDTH  registered result; held until the next Done.
- Carry  out  1  ADD carry-out or SUB borrow; 0 for MUL/DIV.
- DivZero  out  1  DIV with B==0; 0 otherwise.

## Operation
- Reset values: state IDLE, Busy 0, Done 0, Result 0, Carry 0, DivZero 0, internal registers 0.
- Accept: in IDLE with Start=1, the edge latches A, B, Op, clears accumulator/remainder and loads counter=WIDTH-1. Next state:
  - ADD/SUB → EXEC
  - MUL → MTEST
  - DIV with B≠0 → DSHIFT
  - DIV with B==0 → FIN, with DivZero=1 and Result=0
- EXEC:
  - ADD: Result={0…,A+B} zero-extended, Carry=bit WIDTH of the sum.
  - SUB: Result[WIDTH-1:0]=(A-B) mod 2^WIDTH, upper half 0, Carry=(A<B).
  - Next state FIN.
- MTEST: Q0=1 → MADD; else → MSHIFT.
- MADD: {C,Acc}=Acc+M (WIDTH+1-bit add) → MSHIFT.
- MSHIFT: {C,Acc,Q} shifted right 1, C cleared. counter==0 → FIN; else counter-- → MTEST. Final product is {Acc,Q}.
- DSHIFT: {R,Q} shifted left 1 → DSUB.
- DSUB: if R≥D, then R=R-D and Q0=1; else Q0=0. counter==0 → FIN; else counter-- → DSHIFT. Result={R,Q} (remainder high, quotient low).
- FIN: Result, Carry and DivZero registers update on entry to FIN. Done=1 for exactly one cycle, then unconditionally → IDLE.
- Start is ignored in every state other than IDLE, including FIN. It is neither queued nor latched.
- A, B and Op changing while Busy=1 have no effect.
- Reset mid-operation: the next edge forces IDLE and clears all outputs. No Done is produced for the aborted operation.
- Unsigned arithmetic throughout. No overflow is possible for MUL (2*WIDTH result).

## Timing
- Edge e0 is the edge that samples Start=1 in IDLE. "Done after N edges" means Done is high in the cycle following edge e(N-1).
- DIV by zero: Done after 1 edge.
- ADD/SUB: Done after 2 edges.
- MUL: Done after 2*WIDTH+popcount(B)+1 edges. With WIDTH=8: 17 edges for B=0x00, 25 edges for B=0xFF.
- DIV (B≠0): Done after 2*WIDTH+1 edges, i.e. 17 for WIDTH=8.
- Busy rises in the cycle after e0 and falls in the cycle after Done.
- Minimum Start-to-Start spacing is therefore latency+1 cycles. A Start held high continuously is re-accepted on the first IDLE edge after Done.

## Structure
- Package calc_pkg holds: WIDTH default, op_t enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV), and state_t enum (IDLE, EXEC, MTEST, MADD, MSHIFT, DSHIFT, DSUB, FIN).
- Sub-module calc_iter_datapath holds the M/D, Acc/R, Q, C and counter registers plus the adder/subtractor. It is driven by one-hot control strobes (load, add, mshift, dshift, dsub, dec) and returns Q0, cnt_zero and r_ge_d.
- calc_op_sequencer holds the state register, the ADD/SUB execute path and the output registers.

## Test plan
- ADD A=0xC8, B=0x64 → Result=0x012C, Carry=1, DivZero=0; Done after 2 edges; Busy low again the following cycle.
- SUB A=0x05, B=0x0A → Result=0x00FB, Carry=1. Then SUB A=0x0A, B=0x05 → Result=0x0005, Carry=0.
- MUL A=0xFF, B=0xFF → Result=0xFE01, Done after 25 edges. MUL A=0x0D, B=0x00 → Result=0x0000, Done after 17 edges.
- DIV A=0xC8, B=0x07 → Result=0x041C (quotient 28, remainder 4), Done after 17 edges. DIV A=0x55, B=0x00 → DivZero=1, Result=0, Done after 1 edge.
- Pulse Start with Op=ADD and new A/B while a MUL is Busy (MUL A=0x12, B=0x34) → ignored; Result=0x03A8 with a single Done. Then assert Reset at cycle 5 of a subsequent MUL → next cycle Busy=0, Result=0, no Done.
- Start held high across three back-to-back ADDs → each accepted only in IDLE; exactly one Done per operation; Done never coincides with acceptance.
